// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard / pipeline-control unit for the 5-stage RV32 pipeline:
//            load-use detection, long-op scoreboard, branch flush, halt drain.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int unsigned RF_ADDRESS = 5,
    parameter int unsigned MAX_PEND   = 4,
    parameter int unsigned HALT_DRAIN = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [RF_ADDRESS-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_long,
    input  logic                  id_halt,
    input  logic                  ex_memread,
    input  logic [RF_ADDRESS-1:0] ex_rd,
    input  logic                  ex_br_taken,
    input  logic                  wb_long_valid,
    input  logic [RF_ADDRESS-1:0] wb_long_rd,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_if_id,
    output logic                  halted,
    output logic [3:0]            pend_count
);

    localparam int unsigned DEPTH = 2 ** RF_ADDRESS;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] sb_q, sb_d;
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       drain_q, drain_d;

    logic [DEPTH-1:0] wb_clr, sb_set, sb_eff;
    logic             rs1_rd, rs2_rd;
    logic             sb_hit, lu_hit, cap_hit, hz;
    logic             issue, inc, dec;

    // A completing write-back is visible to ID in the same cycle (WB bypass).
    assign wb_clr = wb_long_valid ? ({{(DEPTH-1){1'b0}}, 1'b1} << wb_long_rd) : '0;
    assign sb_set = inc ? ({{(DEPTH-1){1'b0}}, 1'b1} << id_rd) : '0;
    assign sb_eff = sb_q & ~wb_clr;

    assign rs1_rd  = id_use_rs1 && (id_rs1 != '0);
    assign rs2_rd  = id_use_rs2 && (id_rs2 != '0);
    assign sb_hit  = id_valid && ((rs1_rd && sb_eff[id_rs1]) || (rs2_rd && sb_eff[id_rs2]));
    assign lu_hit  = id_valid && ex_memread && (ex_rd != '0) &&
                     ((rs1_rd && (id_rs1 == ex_rd)) || (rs2_rd && (id_rs2 == ex_rd)));
    assign cap_hit = id_valid && id_long && id_regwrite &&
                     (pend_q == 4'(MAX_PEND)) && !wb_long_valid;
    assign hz      = sb_hit || lu_hit || cap_hit;

    assign issue = (state_q == ST_RUN) && id_valid && !hz && !ex_br_taken;
    assign inc   = issue && id_long && id_regwrite && (id_rd != '0);
    assign dec   = wb_long_valid && (pend_q != 4'd0);

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        halted      = 1'b0;
        state_d     = state_q;
        drain_d     = drain_q;
        // Set after clear so an issuing long op wins over a same-cycle completion.
        sb_d        = (sb_q & ~wb_clr) | sb_set;
        pend_d      = pend_q + {3'd0, inc} - {3'd0, dec};

        case (state_q)
            ST_RUN: begin
                if (ex_br_taken) begin
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end else if (hz) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                if (issue && id_halt) begin
                    state_d = ST_DRAIN;
                    drain_d = 4'(HALT_DRAIN);
                end
            end
            ST_DRAIN: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
                if (drain_q != 4'd0) begin
                    drain_d = drain_q - 4'd1;
                end
                if ((drain_d == 4'd0) && (pend_d == 4'd0)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
                halted    = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            sb_q    <= '0;
            pend_q  <= 4'd0;
            drain_q <= 4'd0;
        end else begin
            state_q <= state_d;
            sb_q    <= sb_d;
            pend_q  <= pend_d;
            drain_q <= drain_d;
        end
    end

    assign pend_count = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed plus randomized checking of pipe_hazard_ctrl against a
//            rule-level reference model.
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int MAX_PEND   = 4;
    localparam int HALT_DRAIN = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_long, id_halt;
    logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, wb_long_rd;
    logic       ex_memread, ex_br_taken, wb_long_valid;
    logic       stall_if, stall_id, bubble_ex, flush_if_id, halted;
    logic [3:0] pend_count;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: mode 0 = running, 1 = draining, 2 = halted
    bit m_busy[32];
    int m_pend, m_mode, m_drain_cycles;

    pipe_hazard_ctrl #(.RF_ADDRESS(5), .MAX_PEND(MAX_PEND), .HALT_DRAIN(HALT_DRAIN)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_long(id_long), .id_halt(id_halt),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .wb_long_valid(wb_long_valid), .wb_long_rd(wb_long_rd),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .halted(halted), .pend_count(pend_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0;
        id_long = 0; id_halt = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        ex_memread = 0; ex_rd = 0; ex_br_taken = 0; wb_long_valid = 0; wb_long_rd = 0;
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_pend = 0; m_mode = 0; m_drain_cycles = 0;
    endtask

    function automatic bit reads(input int r);
        return (id_use_rs1 && id_rs1 == r) || (id_use_rs2 && id_rs2 == r);
    endfunction

    function automatic bit waiting_on(input int r);
        return r != 0 && reads(r) && m_busy[r] && !(wb_long_valid && wb_long_rd == r);
    endfunction

    function automatic bit hazard();
        bit h = 0;
        if (!id_valid) return 0;
        for (int r = 1; r < 32; r++) if (waiting_on(r)) h = 1;
        if (ex_memread && ex_rd != 0 && reads(ex_rd)) h = 1;
        if (id_long && id_regwrite && m_pend == MAX_PEND && !wb_long_valid) h = 1;
        return h;
    endfunction

    task automatic compare();
        int e_stall, e_flush, e_bub;
        e_stall = 0; e_flush = 0; e_bub = 0;
        if (m_mode != 0) begin
            e_stall = 1; e_bub = 1;
        end else if (ex_br_taken) begin
            e_flush = 1; e_bub = 1;
        end else if (hazard()) begin
            e_stall = 1; e_bub = 1;
        end
        check("stall_if", stall_if, e_stall);
        check("stall_id", stall_id, e_stall);
        check("bubble_ex", bubble_ex, e_bub);
        check("flush_if_id", flush_if_id, e_flush);
        check("halted", halted, m_mode == 2);
        check("pend_count", pend_count, m_pend);
    endtask

    task automatic model_edge();
        bit issued, grow, shrink;
        issued = (m_mode == 0) && id_valid && !ex_br_taken && !hazard();
        grow   = issued && id_long && id_regwrite && id_rd != 0;
        shrink = wb_long_valid && m_pend > 0;
        if (wb_long_valid) m_busy[wb_long_rd] = 0;
        if (grow) m_busy[id_rd] = 1;
        m_pend = m_pend + int'(grow) - int'(shrink);
        if (m_mode == 1) begin
            m_drain_cycles++;
            if (m_drain_cycles >= HALT_DRAIN && m_pend == 0) m_mode = 2;
        end else if (m_mode == 0 && issued && id_halt) begin
            m_mode = 1; m_drain_cycles = 0;
        end
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        #1 compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic async_reset();
        idle();
        #2 reset = 1;
        model_reset();
        #1 compare();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic issue_long(input int rd);
        idle(); id_valid = 1; id_long = 1; id_regwrite = 1; id_rd = 5'(rd);
        tick();
    endtask

    task automatic read_x(input int r);
        idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'(r);
    endtask

    task automatic issue_halt();
        idle(); id_valid = 1; id_halt = 1;
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);
        #1 compare();
        check("reset_pend", pend_count, 0);
        @(negedge clk);
        reset = 0;

        // Load-use, then the x0 case
        read_x(5); ex_memread = 1; ex_rd = 5;
        #1 check("lu_stall", stall_if, 1);
        tick();
        read_x(0); ex_memread = 1; ex_rd = 0;
        #1 check("lu_x0_nostall", stall_if, 0);
        tick();

        // Long op scoreboard with WB bypass
        issue_long(7);
        for (int i = 0; i < 4; i++) begin
            read_x(7);
            #1 check("sb_stall", stall_id, 1);
            tick();
            check("sb_pend1", pend_count, 1);
        end
        read_x(7); wb_long_valid = 1; wb_long_rd = 7;
        #1 check("sb_bypass", stall_if, 0);
        tick();
        check("sb_pend0", pend_count, 0);
        read_x(7);
        #1 check("sb7_clear", stall_if, 0);
        tick();

        // Capacity
        async_reset();
        for (int r = 1; r <= 4; r++) issue_long(r);
        check("cap_pend4", pend_count, 4);
        idle(); id_valid = 1; id_long = 1; id_regwrite = 1; id_rd = 5;
        #1 check("cap_stall", stall_if, 1);
        tick();
        wb_long_valid = 1; wb_long_rd = 1;
        #1 check("cap_wb_issue", stall_if, 0);
        tick();
        check("cap_pend_hold", pend_count, 4);

        // Flush priority over load-use and halt
        async_reset();
        read_x(5); ex_memread = 1; ex_rd = 5; ex_br_taken = 1; id_halt = 1;
        #1 check("flush_flush", flush_if_id, 1);
        check("flush_stall_if", stall_if, 0);
        tick();
        idle();
        #1 check("flush_no_drain", stall_if, 0);
        tick();

        // Halt drain with two outstanding ops
        async_reset();
        issue_long(1);
        issue_long(2);
        issue_halt();
        for (int k = 1; k <= 5; k++) begin
            idle();
            if (k == 2) begin wb_long_valid = 1; wb_long_rd = 1; end
            if (k == 5) begin wb_long_valid = 1; wb_long_rd = 2; end
            if (k == 3) begin
                ex_br_taken = 1;
                #1 check("drain_no_flush", flush_if_id, 0);
            end
            if (k == 5) check("drain_not_yet", halted, 0);
            tick();
        end
        check("halted_cycle6", halted, 1);

        // Halt drain with nothing outstanding
        async_reset();
        issue_halt();
        for (int k = 1; k <= HALT_DRAIN; k++) begin
            idle();
            check("drain_min", halted, 0);
            tick();
        end
        check("halted_min", halted, 1);

        // Same-cycle set/clear, then reset mid-drain
        async_reset();
        issue_long(9);
        idle(); id_valid = 1; id_long = 1; id_regwrite = 1; id_rd = 9;
        wb_long_valid = 1; wb_long_rd = 9;
        tick();
        check("setclr_pend", pend_count, 1);
        read_x(9);
        #1 check("setclr_sb9", stall_if, 1);
        tick();
        idle(); wb_long_valid = 1; wb_long_rd = 9;
        tick();
        issue_halt();
        idle();
        tick();
        async_reset();
        check("rst_halted", halted, 0);
        check("rst_stall", stall_if, 0);
        idle(); wb_long_valid = 1; wb_long_rd = 3;
        tick();
        check("rst_sat", pend_count, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                id_valid      = $urandom_range(0, 3) != 0;
                id_rs1        = 5'($urandom_range(0, 7));
                id_rs2        = 5'($urandom_range(0, 7));
                id_use_rs1    = 1'($urandom_range(0, 1));
                id_use_rs2    = 1'($urandom_range(0, 1));
                id_rd         = 5'($urandom_range(0, 7));
                id_regwrite   = $urandom_range(0, 3) != 0;
                id_long       = $urandom_range(0, 2) == 0;
                id_halt       = $urandom_range(0, 29) == 0;
                ex_memread    = $urandom_range(0, 2) == 0;
                ex_rd         = 5'($urandom_range(0, 7));
                ex_br_taken   = $urandom_range(0, 7) == 0;
                wb_long_valid = $urandom_range(0, 3) == 0;
                wb_long_rd    = 5'($urandom_range(0, 7));
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
